// File: rtl/exp3_pkg.sv
// Shared state encoding for the exp3 control unit, so the datapath top and
// any observer of db_estado decode the same codes.
package exp3_pkg;

  localparam int ESTADO_W = 4;

  localparam logic [ESTADO_W-1:0] INICIAL = 4'h0;
  localparam logic [ESTADO_W-1:0] PREPARA = 4'h1;
  localparam logic [ESTADO_W-1:0] ESPERA  = 4'h2;
  localparam logic [ESTADO_W-1:0] COMPARA = 4'h3;
  localparam logic [ESTADO_W-1:0] PROXIMO = 4'h4;
  localparam logic [ESTADO_W-1:0] ACERTOU = 4'hA;
  localparam logic [ESTADO_W-1:0] TIMEOUT = 4'hB;
  localparam logic [ESTADO_W-1:0] ERROU   = 4'hE;

endpackage

// File: rtl/unidade_controle_exp3_if.sv
// Control/status bundle between the exp3 control FSM (master) and the
// counter/comparator datapath plus user inputs (slave).
interface unidade_controle_exp3_if;
  import exp3_pkg::*;

  logic                iniciar;
  logic                jogada;
  logic                igual;
  logic                fim;
  logic                zera;
  logic                carrega;
  logic                conta;
  logic                pronto;
  logic                acertou;
  logic                errou;
  logic                timeout;
  logic [ESTADO_W-1:0] db_estado;

  modport master (
    input  iniciar, jogada, igual, fim,
    output zera, carrega, conta, pronto, acertou, errou, timeout, db_estado
  );

  modport slave (
    output iniciar, jogada, igual, fim,
    input  zera, carrega, conta, pronto, acertou, errou, timeout, db_estado
  );

endinterface

// File: rtl/unidade_controle_exp3_edge_detector.sv
// Single-flop rising-edge detector: pulso is high for one cycle when sinal
// goes 0->1 between consecutive samples; a held level yields one pulse.
module edge_detector (
  input  logic clock,
  input  logic reset_n,
  input  logic sinal,
  output logic pulso
);

  logic hist_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) hist_q <= 1'b0;
    else          hist_q <= sinal;
  end

  assign pulso = sinal & ~hist_q;

endmodule

// File: rtl/unidade_controle_exp3.sv
// Moore control FSM for the exp3 guessing round: drives zera/conta on the
// counter datapath and reports win, mismatch or inactivity timeout.
module unidade_controle_exp3
  import exp3_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = 5000
) (
  input  logic                    clock,
  input  logic                    reset_n,
  unidade_controle_exp3_if.master bus
);

  localparam int TIMER_W = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [TIMER_W-1:0] LIMITE = TIMER_W'(TIMEOUT_CICLOS - 1);

  logic [ESTADO_W-1:0] estado_q, estado_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic                jogada_p;

  edge_detector u_edge (
    .clock   (clock),
    .reset_n (reset_n),
    .sinal   (bus.jogada),
    .pulso   (jogada_p)
  );

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      INICIAL: if (bus.iniciar) estado_d = PREPARA;
      PREPARA: estado_d = ESPERA;
      // A jogada arriving on the very cycle the timer expires still counts.
      ESPERA: begin
        if (jogada_p)               estado_d = COMPARA;
        else if (timer_q == LIMITE) estado_d = TIMEOUT;
      end
      COMPARA: begin
        if (!bus.igual)   estado_d = ERROU;
        else if (bus.fim) estado_d = ACERTOU;
        else              estado_d = PROXIMO;
      end
      PROXIMO: estado_d = ESPERA;
      ACERTOU, ERROU, TIMEOUT: if (bus.iniciar) estado_d = PREPARA;
      default: estado_d = INICIAL;
    endcase
  end

  // Timer rests at zero outside ESPERA, so every entry starts from 0.
  always_comb begin
    timer_d = '0;
    if (estado_q == ESPERA) begin
      timer_d = (timer_q == LIMITE) ? timer_q : timer_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q <= INICIAL;
      timer_q  <= '0;
    end else begin
      estado_q <= estado_d;
      timer_q  <= timer_d;
    end
  end

  // Output decode from the state register only; unknown codes decode to all-zero.
  logic                zera_o, conta_o, pronto_o, acertou_o, errou_o, timeout_o;
  logic [ESTADO_W-1:0] db_estado_o;

  always_comb begin
    zera_o      = 1'b0;
    conta_o     = 1'b0;
    pronto_o    = 1'b0;
    acertou_o   = 1'b0;
    errou_o     = 1'b0;
    timeout_o   = 1'b0;
    db_estado_o = estado_q;
    case (estado_q)
      INICIAL, ESPERA, COMPARA: ;
      PREPARA: zera_o = 1'b1;
      PROXIMO: conta_o = 1'b1;
      ACERTOU: begin pronto_o = 1'b1; acertou_o = 1'b1; end
      ERROU:   begin pronto_o = 1'b1; errou_o   = 1'b1; end
      TIMEOUT: begin pronto_o = 1'b1; timeout_o = 1'b1; end
      default: db_estado_o = INICIAL;
    endcase
  end

  assign bus.zera      = zera_o;
  assign bus.carrega   = 1'b0;
  assign bus.conta     = conta_o;
  assign bus.pronto    = pronto_o;
  assign bus.acertou   = acertou_o;
  assign bus.errou     = errou_o;
  assign bus.timeout   = timeout_o;
  assign bus.db_estado = db_estado_o;

endmodule
